// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a 1-bit ALU slice LSB-first over WIDTH cycles.
// Optional zero_flag output enabled by defining ALU_SERIAL_SEQ_ZERO_FLAG_EN.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
  output logic             zero_flag,
`endif
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_sel,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [2:0]       sel_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             addsub;

  always_comb begin
    res_next = {slice_result, res_sr[WIDTH-1:1]};
    addsub   = (sel_r[2:1] == 2'b00);
  end

  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_sel = 3'b000;
    if (state == S_RUN) begin
      slice_a   = a_sr[0];
      slice_b   = b_sr[0];
      slice_cin = carry;
      slice_sel = sel_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      sel_r     <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout_out  <= 1'b0;
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
      zero_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr   <= opa;
            b_sr   <= opb;
            sel_r  <= op;
            carry  <= (op[2:1] == 2'b00) ? cin_in : 1'b0;
            cnt    <= '0;
            res_sr <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          cnt    <= cnt + 1'b1;
          carry  <= addsub ? slice_cout : 1'b0;
          // Outputs are captured at the edge ending the last bit so they are
          // already valid during the single DONE cycle that pulses done.
          if (cnt == LAST) begin
            result    <= res_next;
            cout_out  <= addsub ? slice_cout : 1'b0;
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
            zero_flag <= (res_next == '0);
`endif
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq with a behavioural 1-bit slice attached.
module tb_alu_serial_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout_out;
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
  logic         zero_flag;
`endif
  logic         slice_a;
  logic         slice_b;
  logic         slice_cin;
  logic [2:0]   slice_sel;
  logic         slice_result;
  logic         slice_cout;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .opa          (opa),
    .opb          (opb),
    .cin_in       (cin_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .cout_out     (cout_out),
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
    .zero_flag    (zero_flag),
`endif
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_cin    (slice_cin),
    .slice_sel    (slice_sel),
    .slice_result (slice_result),
    .slice_cout   (slice_cout)
  );

  always #5 clk = ~clk;

  // Behavioural slice: the environment the sequencer drives.
  always_comb begin
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    case (slice_sel)
      3'b000: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      3'b001: begin
        slice_result = slice_a ^ slice_b ^ slice_cin;
        slice_cout   = (~slice_a & slice_b) | (~slice_a & slice_cin) | (slice_b & slice_cin);
      end
      3'b010: slice_result = slice_a & slice_b;
      3'b011: slice_result = slice_a;
      3'b100: slice_result = slice_a & slice_b;
      3'b101: slice_result = slice_a | slice_b;
      3'b110: slice_result = slice_a ^ slice_b;
      default: slice_result = ~(slice_a ^ slice_b);
    endcase
  end

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.r));
        chk("cout_out", 32'(cout_out), 32'(mon_e.c));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
        chk("zero_flag", 32'(zero_flag), 32'(mon_e.r == '0));
`endif
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_cout"}, 32'(cout_out), 32'd0);
    chk({tag, "_slice_ab"}, 32'({slice_a, slice_b, slice_cin}), 32'd0);
    chk({tag, "_slice_sel"}, 32'(slice_sel), 32'd0);
`ifdef ALU_SERIAL_SEQ_ZERO_FLAG_EN
    chk({tag, "_zero_flag"}, 32'(zero_flag), 32'd0);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 60), 32'd1);
  endtask

  // One operation; inject_at pulses a competing start, abort_at asserts rst.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                        input logic ci, input logic [W-1:0] er, input logic ec,
                        input int inject_at, input int abort_at);
    exp_t e;
    @(negedge clk);
    opa = a; opb = b; op = o; cin_in = ci; start = 1'b1;
    if (abort_at < 0) begin
      e.r = er; e.c = ec; e.cyc = cyc + 17;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("slice_a", 32'(slice_a), 32'(a[i]));
      chk("slice_b", 32'(slice_b), 32'(b[i]));
      chk("slice_sel", 32'(slice_sel), 32'(o));
      if (o[2:1] != 2'b00) chk("slice_cin_zero", 32'(slice_cin), 32'd0);
      else if (i == 0) chk("slice_cin_init", 32'(slice_cin), 32'(ci));
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        return;
      end
      start = (i == inject_at);
      if (i == inject_at) begin
        op = 3'b101;
        opa = '1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_done_cycle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] prev;
    int c0;
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, 3'b000, 1'b0, 16'h2233, 1'b0, -1, -1); wait_idle();
    run_op(16'hFFFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 1'b1, -1, -1); wait_idle();
    run_op(16'h0005, 16'h0003, 3'b001, 1'b0, 16'h0002, 1'b0, -1, -1); wait_idle();
    run_op(16'h0003, 16'h0005, 3'b001, 1'b0, 16'hFFFE, 1'b1, -1, -1); wait_idle();
    run_op(16'hA5A5, 16'h0FF0, 3'b110, 1'b0, 16'hAA55, 1'b0, -1, -1); wait_idle();
    run_op(16'hA5A5, 16'h0FF0, 3'b111, 1'b1, 16'h55AA, 1'b0, -1, -1); wait_idle();
    run_op(16'h0007, 16'h0008, 3'b000, 1'b1, 16'h0010, 1'b0, -1, -1); wait_idle();
    run_op(16'h0005, 16'h0003, 3'b001, 1'b1, 16'h0001, 1'b0, -1, -1); wait_idle();
    run_op(16'h0100, 16'h0023, 3'b000, 1'b0, 16'h0123, 1'b0, 5, -1); wait_idle();
    run_op(16'h00FF, 16'hFF00, 3'b101, 1'b0, 16'hFFFF, 1'b0, -1, 8);
    repeat (20) @(negedge clk);
    chk("post_abort_result", 32'(result), 32'd0);

    // Back-to-back with start held: accepts every 18 cycles.
    @(negedge clk);
    c0 = cyc;
    opa = 16'h0001; opb = 16'h0002; op = 3'b000; cin_in = 1'b0; start = 1'b1;
    e.r = 16'h0003; e.c = 1'b0; e.cyc = c0 + 17; sb.push_back(e);
    prev = result;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        opa = 16'h0010; opb = 16'h0001; op = 3'b001;
        e.r = 16'h000F;
      end else begin
        opa = 16'hF0F0; opb = 16'h3C3C; op = 3'b100;
        e.r = 16'h3030;
      end
      e.c = 1'b0; e.cyc = c0 + 18 * k + 17; sb.push_back(e);
      for (int j = 0; j < 17; j++) begin
        if (!done) chk("result_held", 32'(result), 32'(prev));
        prev = result;
        @(negedge clk);
      end
      chk("b2b_idle_busy", 32'({busy, done}), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
